// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter.
//   state_t          transmitter FSM states
//   ERR_*            tx_err_code values
//   CMD_*            common keyboard command bytes
//   frame()          {stop, odd parity, data} shift-register image of a byte
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, ERROR} state_t;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    function automatic logic [9:0] frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction
endpackage

// File: rtl/ps2_tx_if.sv
// ps2_tx_if: request/status bundle between a command source and ps2_tx.
//   tx_start/tx_data          request (master -> slave)
//   tx_busy/rx_inhibit        transfer in progress
//   tx_done_tick/tx_err_tick  completion pulses
//   tx_err_code               result of the last transfer
interface ps2_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_inhibit;
    logic       tx_done_tick;
    logic       tx_err_tick;
    logic [1:0] tx_err_code;
    modport master (output tx_start, tx_data,
                    input  tx_busy, rx_inhibit, tx_done_tick, tx_err_tick, tx_err_code);
    modport slave  (input  tx_start, tx_data,
                    output tx_busy, rx_inhibit, tx_done_tick, tx_err_tick, tx_err_code);
endinterface

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: 2-flop synchronizer, FILTER_LEN-sample debounce and falling-edge strobe.
//   CLOCK_50, reset   system clock, asynchronous active-high reset
//   pin               raw asynchronous line level
//   level             debounced level (idles high)
//   fall_edge         one-cycle strobe when level goes 1 -> 0
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall_edge
);
    localparam int W = $clog2(FILTER_LEN + 1);
    logic [1:0]   sync;
    logic [W-1:0] cnt;
    // cnt counts consecutive synchronized samples that disagree with level
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync      <= 2'b11;
            cnt       <= '0;
            level     <= 1'b1;
            fall_edge <= 1'b0;
        end else begin
            sync      <= {sync[0], pin};
            fall_edge <= 1'b0;
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == W'(FILTER_LEN - 1)) begin
                level     <= sync[1];
                cnt       <= '0;
                fall_edge <= level;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter with open-drain drive enables.
//   CLOCK_50, reset                  system clock, asynchronous active-high reset
//   bus (ps2_tx_if.slave)            tx_start/tx_data in; busy, rx_inhibit, ticks, err code out
//   ps2c_in, ps2d_in                 raw PS2_CLK / PS2_DAT pin levels
//   ps2c_drive_low, ps2d_drive_low   1 = pull line low, 0 = release
// Optional macro PS2_TX_RETRY_EN: retry a failed transfer up to RETRY_MAX times.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int RETRY_MAX      = 2
) (
    input  logic CLOCK_50,
    input  logic reset,
    ps2_tx_if.slave bus,
    input  logic ps2c_in,
    input  logic ps2d_in,
    output logic ps2c_drive_low,
    output logic ps2d_drive_low
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        state, next;
    logic          c_lvl, c_fall, d_lvl, unused_d_fall;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    logic [3:0]    ecnt;
    logic [9:0]    sh;
    logic [7:0]    data_q;
    logic [1:0]    code;
    logic          start_ok, inh_last, active, timeout, nack, fail, can_retry;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (
        .CLOCK_50(CLOCK_50), .reset(reset), .pin(ps2c_in), .level(c_lvl), .fall_edge(c_fall));
    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_dat (
        .CLOCK_50(CLOCK_50), .reset(reset), .pin(ps2d_in), .level(d_lvl), .fall_edge(unused_d_fall));

    assign start_ok = state == IDLE && bus.tx_start;
    assign inh_last = icnt == IW'(INHIBIT_CYCLES - 1);
    assign active   = state inside {RTS, SEND, ACK, WAIT_IDLE};
    assign timeout  = active && tcnt == TW'(TIMEOUT_CYCLES - 1);
    // timeout wins over an edge arriving in the same cycle
    assign nack     = state == ACK && c_fall && d_lvl && !timeout;
    assign fail     = timeout || nack;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_cnt;
    assign can_retry = retry_cnt != 2'(RETRY_MAX);
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            retry_cnt <= '0;
        else if (start_ok)
            retry_cnt <= '0;
        else if (fail && can_retry)
            retry_cnt <= retry_cnt + 1'b1;
    end
`else
    localparam int unused_retry_max = RETRY_MAX;
    assign can_retry = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        if (fail)
            next = can_retry ? INHIBIT : ERROR;
        else
            case (state)
                IDLE:      next = bus.tx_start ? INHIBIT : IDLE;
                INHIBIT:   next = inh_last ? RTS : INHIBIT;
                RTS:       next = c_fall ? SEND : RTS;
                SEND:      next = (c_fall && ecnt == 4'd9) ? ACK : SEND;
                ACK:       next = c_fall ? WAIT_IDLE : ACK;
                WAIT_IDLE: next = (c_lvl && d_lvl) ? IDLE : WAIT_IDLE;
                ERROR:     next = IDLE;
                default:   next = IDLE;
            endcase
    end

    // edge 1 (in RTS) exposes data[0]; each later edge in SEND shifts the next bit out
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            icnt   <= '0;
            tcnt   <= '0;
            ecnt   <= '0;
            sh     <= '0;
            data_q <= '0;
            code   <= ERR_NONE;
        end else begin
            icnt <= state == INHIBIT ? icnt + 1'b1 : '0;
            tcnt <= active ? tcnt + 1'b1 : '0;
            if (start_ok) begin
                data_q <= bus.tx_data;
                code   <= ERR_NONE;
            end
            if (state == INHIBIT) begin
                sh   <= frame(data_q);
                ecnt <= '0;
            end else if (c_fall && (state == RTS || state == SEND)) begin
                ecnt <= ecnt + 1'b1;
                if (state == SEND)
                    sh <= {1'b1, sh[9:1]};
            end
            if (fail && !can_retry)
                code <= timeout ? ERR_TIMEOUT : ERR_NACK;
        end
    end

    always_comb begin
        ps2c_drive_low   = state == INHIBIT;
        ps2d_drive_low   = (state == INHIBIT && inh_last) || state == RTS || (state == SEND && !sh[0]);
        bus.tx_busy      = state != IDLE;
        bus.rx_inhibit   = state != IDLE;
        bus.tx_done_tick = state == WAIT_IDLE && c_lvl && d_lvl && !timeout;
        bus.tx_err_tick  = state == ERROR;
        bus.tx_err_code  = code;
    end
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed, table-driven bench for ps2_tx with a cycle-level PS/2 device model.
module tb_ps2_tx;
    import ps2_pkg::*;
    localparam int INH = 400;
    localparam int TMO = 3000;
    localparam int H   = 50;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic clk = 1'b0, reset = 1'b1, dev_c = 1'b1, dev_d = 1'b1;
    logic c_low, d_low, ps2c_in, ps2d_in;
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, run = 0, inh_len = 0, inh_runs = 0, rts_cyc = 0, err_cyc = 0;
    int   done_cnt = 0, err_cnt = 0;
    logic last_d = 1'b0, inh_d = 1'b0;

    ps2_tx_if bus();
    ps2_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .RETRY_MAX(2)) dut (
        .CLOCK_50(clk), .reset(reset), .bus(bus), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_drive_low(c_low), .ps2d_drive_low(d_low));

    assign ps2c_in = dev_c & ~c_low;
    assign ps2d_in = dev_d & ~d_low;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (c_low) begin
            run    <= run + 1;
            last_d <= d_low;
        end else if (run != 0) begin
            inh_len  <= run;
            inh_d    <= last_d;
            inh_runs <= inh_runs + 1;
            rts_cyc  <= cyc;
            run      <= 0;
        end
        if (bus.tx_done_tick) done_cnt <= done_cnt + 1;
        if (bus.tx_err_tick) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         poke;
        bit         glitch;
        logic [9:0] frame;
        logic [1:0] code;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_start(input logic [7:0] d);
        @(negedge clk);
        chk("pre_start_clk_low", c_low, 0);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
        bus.tx_start = 1'b0;
        chk("start_latency_clk_low", c_low, 1);
        chk("busy_after_start", bus.tx_busy, 1);
        chk("rx_inhibit_after_start", bus.rx_inhibit, 1);
    endtask

    task automatic wait_rts(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < INH + 200; i++) begin
            @(negedge clk);
            #1;
            if (!c_low && d_low) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic dev_frame(input bit ack, input bit poke, input bit glitch, output logic [9:0] f);
        for (int k = 1; k <= 10; k++) begin
            if (glitch && k == 5) begin
                wait_n(20);
                dev_c = 1'b0;
                wait_n(5);
                dev_c = 1'b1;
                wait_n(H - 25);
            end else
                wait_n(H);
            dev_c = 1'b0;
            wait_n(H / 2);
            if (poke && k == 3) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'h00;
                @(negedge clk);
                bus.tx_start = 1'b0;
                @(negedge clk);
            end else
                wait_n(2);
            wait_n(H / 2 - 2);
            dev_c = 1'b1;
            f[k-1] = ps2d_in;
        end
        dev_d = ack ? 1'b0 : 1'b1;
        wait_n(H);
        dev_c = 1'b0;
        wait_n(H);
        dev_c = 1'b1;
        wait_n(5);
        dev_d = 1'b1;
    endtask

    task automatic wait_not_busy(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!bus.tx_busy) break;
        end
    endtask

    task automatic run_vec(input int i);
        int         d0, e0, attempts;
        bit         ok;
        logic [9:0] f;
        d0 = done_cnt;
        e0 = err_cnt;
        f  = '0;
        attempts = vecs[i].ack ? 1 : ATTEMPTS;
        send_start(vecs[i].data);
        for (int a = 0; a < attempts; a++) begin
            wait_rts(ok);
            chk("rts_reached", ok, 1);
            chk("inhibit_len", inh_len, INH);
            chk("start_bit_on_last_inhibit", inh_d, 1);
            dev_frame(vecs[i].ack, vecs[i].poke, vecs[i].glitch, f);
        end
        wait_not_busy(300);
        chk("frame_bits", f, vecs[i].frame);
        chk("err_code", bus.tx_err_code, vecs[i].code);
        chk("done_ticks", done_cnt - d0, vecs[i].ack ? 1 : 0);
        chk("err_ticks", err_cnt - e0, vecs[i].ack ? 0 : 1);
        chk("busy_end", bus.tx_busy, 0);
        chk("drives_end", {c_low, d_low}, 0);
    endtask

    initial begin
        int  d0, e0, r0;
        bit  ok;
        vecs[0] = '{CMD_SET_LED, 1'b1, 1'b0, 1'b0, 10'b11_1110_1101, ERR_NONE};
        vecs[1] = '{8'h01,       1'b1, 1'b0, 1'b0, 10'b10_0000_0001, ERR_NONE};
        vecs[2] = '{CMD_RESET,   1'b1, 1'b0, 1'b0, 10'b11_1111_1111, ERR_NONE};
        vecs[3] = '{8'hA5,       1'b0, 1'b0, 1'b0, 10'b11_1010_0101, ERR_NACK};
        vecs[4] = '{8'h3C,       1'b1, 1'b1, 1'b1, 10'b11_0011_1100, ERR_NONE};
        vecs[5] = '{CMD_ENABLE,  1'b1, 1'b0, 1'b0, 10'b10_1111_0100, ERR_NONE};
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        wait_n(5);
        reset = 1'b0;
        wait_n(3);
        chk("rst_clk_drive", c_low, 0);
        chk("rst_dat_drive", d_low, 0);
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_rx_inhibit", bus.rx_inhibit, 0);
        chk("rst_done", bus.tx_done_tick, 0);
        chk("rst_err", bus.tx_err_tick, 0);
        chk("rst_code", bus.tx_err_code, ERR_NONE);

        for (int i = 0; i < 5; i++) begin
            run_vec(i);
            wait_n(20);
        end

        // reset after edge 4 of 0xA5: bit 3 is 0, so data is being pulled low
        send_start(8'hA5);
        wait_rts(ok);
        chk("rst_seq_rts", ok, 1);
        for (int k = 0; k < 4; k++) begin
            wait_n(H);
            dev_c = 1'b0;
            wait_n(H);
            dev_c = 1'b1;
        end
        wait_n(2);
        chk("pre_reset_dat_drive", d_low, 1);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_clk_drive", c_low, 0);
        chk("async_rst_dat_drive", d_low, 0);
        chk("async_rst_busy", bus.tx_busy, 0);
        wait_n(3);
        reset = 1'b0;
        wait_n(20);
        run_vec(5);
        wait_n(20);

        // device never clocks
        d0 = done_cnt;
        e0 = err_cnt;
        r0 = inh_runs;
        send_start(8'h55);
        wait_not_busy(ATTEMPTS * (INH + TMO) + 500);
        chk("tmo_busy_end", bus.tx_busy, 0);
        chk("tmo_err_ticks", err_cnt - e0, 1);
        chk("tmo_done_ticks", done_cnt - d0, 0);
        chk("tmo_code", bus.tx_err_code, ERR_TIMEOUT);
        chk("tmo_latency", err_cyc - rts_cyc, TMO);
        chk("tmo_inhibit_phases", inh_runs - r0, ATTEMPTS);
        chk("tmo_drives", {c_low, d_low}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter; the send-side counterpart of the existing ps2_rx receiver on the same PS2_CLK/PS2_DAT pins.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Produces open-drain drive-low enables for the top-level tristate.
- While busy, it holds off ps2_rx through rx_inhibit.

Parameters:
- INHIBIT_CYCLES, 5000: clock-line hold-low time (100 us at 50 MHz).
- FILTER_LEN, 8: consecutive equal samples needed to accept a PS/2 clock level.
- TIMEOUT_CYCLES, 750000: maximum frame duration after clock release (15 ms).
- RETRY_MAX, 2: automatic retries; used only with PS2_TX_RETRY_EN.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_start  in  1  one-cycle request; accepted only in IDLE.
- tx_data  in  8  byte to send; latched on accepted tx_start.
- ps2c_in  in  1  PS2_CLK pin level (asynchronous).
- ps2d_in  in  1  PS2_DAT pin level (asynchronous).
- ps2c_drive_low  out  1  1 = pull PS2_CLK low, 0 = release (Z).
- ps2d_drive_low  out  1  1 = pull PS2_DAT low, 0 = release (Z).
- tx_busy  out  1  high from accepted start until return to IDLE.
- rx_inhibit  out  1  equals tx_busy; top level ties ps2_rx rx_en to ~rx_inhibit.
- tx_done_tick  out  1  one-cycle pulse: byte acknowledged, bus idle.
- tx_err_tick  out  1  one-cycle pulse: transfer failed.
- tx_err_code  out  2  00 none, 01 NACK, 10 timeout; held until next accepted start.

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset is asynchronous, so both drive_low outputs release immediately, including mid-frame.
- Input conditioning: 2-flop synchronizers on ps2c_in and ps2d_in. Filtered clock level changes only after FILTER_LEN equal samples. fall_edge is a one-cycle strobe on a filtered 1->0 transition.
- Frame: shift register {stop=1, parity=~^tx_data, tx_data}, sent LSB first. Parity is odd.
- IDLE: both lines released. On tx_start, latch data, clear err_code, set busy, go to INHIBIT. tx_start while busy is ignored.
- INHIBIT: ps2c_drive_low=1 for INHIBIT_CYCLES cycles. On the final cycle, ps2d_drive_low=1 (start bit). Then go to RTS.
- RTS: clock released, data held low. Edge counter = 0; timeout counter starts.
- SEND: on each fall_edge, edge counter increments.
  - Edges 1-8: ps2d_drive_low = ~data[i].
  - Edge 9: ps2d_drive_low = ~parity.
  - Edge 10: data released (stop bit).
  - Then go to ACK.
- ACK: on edge 11, sample filtered data. Low = ACK, go to WAIT_IDLE. High = NACK, go to ERROR with code 01.
- WAIT_IDLE: wait until filtered clock and data are both high, then tx_done_tick, busy=0, IDLE.
- ERROR: release both lines, pulse tx_err_tick, go to IDLE.
- Timeout: if the timeout counter reaches TIMEOUT_CYCLES in any state from RTS through WAIT_IDLE, go to ERROR with code 10. Timeout takes priority over a simultaneous fall_edge.
- Latency: first drive_low asserts the cycle after the accepted tx_start.
- Done/err ticks are mutually exclusive and never coincide with busy rising.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, restart from INHIBIT with the same latched byte, up to RETRY_MAX times.
  - tx_err_tick fires only after the final failed attempt.
  - tx_busy stays high throughout retries.
  - A 2-bit retry counter is cleared on each accepted start.
- Undefined: the first failure goes directly to ERROR; no retry logic is synthesized.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, ERROR);
  - error-code constants ERR_NONE/ERR_NACK/ERR_TIMEOUT;
  - command constants CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
- Sub-module ps2_clk_filter: synchronizer, FILTER_LEN debounce and fall_edge strobe. Reusable by ps2_rx.

Test Plan:
- Nominal ACK: tx_start with 0xED; device model toggles every 2000 cycles and ACKs.
  - Clock held low 5000 cycles.
  - Data bits LSB first 1,0,1,1,0,1,1,1; parity 1; stop released.
  - tx_done_tick once; err_code 00.
- Parity: send 0x01 -> parity bit 0 (data released? no: driven low) at edge 9. Send 0xFF -> parity 1.
- NACK: model leaves data high at edge 11 -> tx_err_tick, err_code 01, both drives 0, busy 0.
- Timeout: model never clocks -> err_code 10 exactly TIMEOUT_CYCLES after RTS entry. With PS2_TX_RETRY_EN: 3 INHIBIT phases, then a single tx_err_tick.
- Reset mid-frame: assert reset after edge 4 -> drive outputs 0 asynchronously; busy 0; the next tx_start of 0xF4 completes normally.
- Robustness:
  - tx_start pulse during SEND is ignored; the frame is unchanged.
  - A 5-cycle low glitch on ps2c_in is not counted as an edge.
